alu_pipe: RTL and testbench

// Registered, parametrised-width ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_pipe_if.sv | 26 ++
 rtl/alu_mul_seq.sv | 65 ++++++
 rtl/alu_pipe.sv | 167 ++++++++++++++++
 tb/tb_alu_pipe.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions,
// FSM state encoding and the flag packing helper.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOT   = 4'd5;
   localparam logic [3:0] OP_PASS1 = 4'd6;
   localparam logic [3:0] OP_PASS2 = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;
   localparam logic [3:0] OP_SAR   = 4'd10;
   localparam logic [3:0] OP_MUL   = 4'd11;
   localparam logic [3:0] OP_CMP   = 4'd12;

   localparam int FLG_Z  = 4;
   localparam int FLG_CY = 3;
   localparam int FLG_S  = 2;
   localparam int FLG_P  = 1;
   localparam int FLG_OV = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   function automatic logic [4:0] pack_flags(input logic z, input logic cy, input logic s,
                                             input logic p, input logic ov);
      logic [4:0] f;
      f         = '0;
      f[FLG_Z]  = z;
      f[FLG_CY] = cy;
      f[FLG_S]  = s;
      f[FLG_P]  = p;
      f[FLG_OV] = ov;
      return f;
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/result bundle between the operand mux (master) and the ALU (slave).
interface alu_pipe_if #(parameter int W = 16);

   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opcode;
   logic [W-1:0] arg1;
   logic [W-1:0] arg2;
   logic [4:0]   in_flg;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] res;
   logic [4:0]   out_flg;
   logic         wr_en;

   modport master (
      output in_valid, opcode, arg1, arg2, in_flg, out_ready,
      input  in_ready, out_valid, res, out_flg, wr_en
   );

   modport slave (
      input  in_valid, opcode, arg1, arg2, in_flg, out_ready,
      output in_ready, out_valid, res, out_flg, wr_en
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: the first iteration happens on the start
// edge, so done pulses W-1 edges later with the full product.
module alu_mul_seq #(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] prod
);

   localparam int CW = $clog2(W);

   logic [2*W-1:0] mcand_reg;
   logic [2*W-1:0] acc_reg;
   logic [W-1:0]   mplier_reg;
   logic [CW-1:0]  cnt_reg;
   logic           busy_reg;
   logic           done_reg;
   logic [2*W-1:0] addend;

   // Partial product for the current multiplier bit.
   genvar gi;
   generate
      for (gi = 0; gi < 2*W; gi++) begin : g_addend
         assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_reg  <= '0;
         acc_reg    <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            acc_reg    <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand_reg  <= {{(W-1){1'b0}}, a, 1'b0};
            mplier_reg <= b >> 1;
            cnt_reg    <= CW'(W-1);
            busy_reg   <= 1'b1;
         end else if (busy_reg) begin
            acc_reg    <= acc_reg + addend;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done = done_reg;
   assign prod = acc_reg;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; single-cycle ops complete on the
// accepting edge, MUL parks the FSM until the sequential multiplier finishes.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int W = 16
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);

   localparam int SHW = $clog2(W);

   state_t         state_reg;
   logic           out_valid_reg;
   logic           wr_en_reg;
   logic [W-1:0]   res_reg;
   logic [4:0]     flg_reg;

   logic           accept;
   logic           is_mul;
   logic           cin;
   logic [W-1:0]   a1;
   logic [W-1:0]   a2;
   logic [SHW-1:0] amt;
   logic [W:0]     sum_ext;
   logic [W:0]     diff_ext;
   logic [W:0]     shl_ext;
   logic [W:0]     shr_ext;
   logic [W:0]     sar_ext;
   logic signed [W:0] sar_src;

   logic [W-1:0]   alu_res;
   logic           alu_cy;
   logic           alu_ov;
   logic           alu_wr;
   logic [4:0]     alu_flg;

   logic           mul_done;
   logic [2*W-1:0] mul_prod;
   logic [W-1:0]   mul_lo;
   logic           mul_hi;
   logic [4:0]     mul_flg;

   assign bus.in_ready = (state_reg == ST_IDLE) & (~out_valid_reg | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;
   assign is_mul       = (bus.opcode == OP_MUL);

   assign cin = bus.in_flg[FLG_CY];
   assign a1  = bus.arg1;
   assign a2  = bus.arg2;
   assign amt = a2[SHW-1:0];

   // One guard bit on each shift catches the last bit shifted out as CY.
   assign sum_ext  = {1'b0, a1} + {1'b0, a2} + {{W{1'b0}}, cin};
   assign diff_ext = {1'b0, a1} - {1'b0, a2} - {{W{1'b0}}, cin};
   assign shl_ext  = {1'b0, a1} << amt;
   assign shr_ext  = {a1, 1'b0} >> amt;
   assign sar_src  = {a1, 1'b0};
   assign sar_ext  = sar_src >>> amt;

   always_comb begin
      alu_res = a1;
      alu_cy  = 1'b0;
      alu_ov  = 1'b0;
      alu_wr  = 1'b1;
      case (bus.opcode)
         OP_ADD: begin
            alu_res = sum_ext[W-1:0];
            alu_cy  = sum_ext[W];
            alu_ov  = (a1[W-1] == a2[W-1]) & (sum_ext[W-1] != a1[W-1]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = diff_ext[W-1:0];
            alu_cy  = diff_ext[W];
            alu_ov  = (a1[W-1] != a2[W-1]) & (diff_ext[W-1] != a1[W-1]);
            alu_wr  = (bus.opcode != OP_CMP);
         end
         OP_AND:   alu_res = a1 & a2;
         OP_OR:    alu_res = a1 | a2;
         OP_XOR:   alu_res = a1 ^ a2;
         OP_NOT:   alu_res = ~a1;
         OP_PASS1: begin
            alu_res = a1;
            alu_cy  = cin;
         end
         OP_PASS2: begin
            alu_res = a2;
            alu_cy  = cin;
         end
         OP_SHL: begin
            alu_res = shl_ext[W-1:0];
            alu_cy  = shl_ext[W];
         end
         OP_SHR: begin
            alu_res = shr_ext[W:1];
            alu_cy  = shr_ext[0];
         end
         OP_SAR: begin
            alu_res = sar_ext[W:1];
            alu_cy  = sar_ext[0];
         end
         default: begin
            alu_res = a1;
         end
      endcase
      alu_flg = pack_flags(~|alu_res, alu_cy, alu_res[W-1], ^alu_res, alu_ov);
   end

   alu_mul_seq #(.W(W)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (accept & is_mul),
      .a     (a1),
      .b     (a2),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   assign mul_lo  = mul_prod[W-1:0];
   assign mul_hi  = |mul_prod[2*W-1:W];
   assign mul_flg = pack_flags(~|mul_lo, mul_hi, mul_lo[W-1], ^mul_lo, mul_hi);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         out_valid_reg <= 1'b0;
         res_reg       <= '0;
         flg_reg       <= '0;
         wr_en_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept && is_mul) begin
                  // Any pending result was consumed on this edge; nothing valid until MUL ends.
                  state_reg     <= ST_MUL;
                  out_valid_reg <= 1'b0;
               end else if (accept) begin
                  res_reg       <= alu_res;
                  flg_reg       <= alu_flg;
                  wr_en_reg     <= alu_wr;
                  out_valid_reg <= 1'b1;
               end else if (out_valid_reg && bus.out_ready) begin
                  out_valid_reg <= 1'b0;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  res_reg       <= mul_lo;
                  flg_reg       <= mul_flg;
                  wr_en_reg     <= 1'b1;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.res       = res_reg;
   assign bus.out_flg   = flg_reg;
   assign bus.wr_en     = wr_en_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe at W=16 with hand-computed expected results.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_pipe_if #(.W(W)) bus ();

   alu_pipe #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.arg1     = a;
      bus.arg2     = b;
      bus.in_flg   = {1'b0, cin, 3'b000};
   endtask

   task automatic test_reset;
      logic [22:0] got;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.opcode    = 4'd0;
      bus.arg1      = '0;
      bus.arg2      = '0;
      bus.in_flg    = 5'b0;
      tick;
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      $display("txn reset: out_valid=%b wr_en=%b flg=%b res=%h", bus.out_valid, bus.wr_en, bus.out_flg, bus.res);
      n_vec++;
      if (got !== 23'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want %h", got, 23'h0);
      end
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_add;
      logic [22:0] got, exp;
      bus.out_ready = 1'b1;
      drive(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00111, 16'h8000};
      $display("txn add_ovf: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL add_ovf: got %h want %h", got, exp);
      end
      drive(OP_ADD, 16'hFFFF, 16'h0000, 1'b1);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b11000, 16'h0000};
      $display("txn add_cin: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL add_cin: got %h want %h", got, exp);
      end
      bus.in_valid = 1'b0;
      tick;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL add_drain: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_sub_cmp;
      logic [22:0] got, exp;
      drive(OP_SUB, 16'h0000, 16'h0001, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b01100, 16'hFFFF};
      $display("txn sub: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL sub_borrow: got %h want %h", got, exp);
      end
      drive(OP_CMP, 16'h0000, 16'h0001, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b0, 5'b01100, 16'hFFFF};
      $display("txn cmp: res=%h flg=%b wr_en=%b", bus.res, bus.out_flg, bus.wr_en);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL cmp: got %h want %h", got, exp);
      end
      drive(OP_SUB, 16'h8000, 16'h0001, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00011, 16'h7FFF};
      $display("txn sub_ovf: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL sub_ovf: got %h want %h", got, exp);
      end
      bus.in_valid = 1'b0;
      tick;
   endtask

   task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input logic [4:0] exp_flg);
      logic [22:0] got, exp;
      int cycles;
      int ready_hi;
      bus.out_ready = 1'b1;
      drive(OP_MUL, a, b, 1'b0);
      tick;
      bus.in_valid = 1'b0;
      cycles   = 0;
      ready_hi = 0;
      while (bus.out_valid !== 1'b1 && cycles < 40) begin
         if (bus.in_ready !== 1'b0) ready_hi++;
         tick;
         cycles++;
      end
      $display("txn mul %h*%h: latency=%0d res=%h flg=%b", a, b, cycles, bus.res, bus.out_flg);
      n_vec++;
      if (cycles != 16) begin
         n_err++;
         $display("FAIL mul_latency: got %0d want 16", cycles);
      end
      n_vec++;
      if (ready_hi != 0) begin
         n_err++;
         $display("FAIL mul_in_ready: high for %0d cycles want 0", ready_hi);
      end
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, exp_flg, exp_res};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL mul_result: got %h want %h", got, exp);
      end
      tick;
   endtask

   task automatic test_backpressure;
      logic [22:0] got, exp;
      bus.out_ready = 1'b0;
      drive(OP_XOR, 16'hF0F0, 16'h0FF0, 1'b0);
      tick;
      // Held request must be ignored while the result is stalled.
      drive(OP_OR, 16'h1200, 16'h0034, 1'b1);
      exp = {1'b1, 1'b1, 5'b00100, 16'hFF00};
      for (int i = 0; i < 3; i++) begin
         got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
         $display("txn bp_stall%0d: res=%h flg=%b in_ready=%b", i, bus.res, bus.out_flg, bus.in_ready);
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL bp_hold%0d: got %h want %h", i, got, exp);
         end
         n_vec++;
         if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready%0d: got %b want 0", i, bus.in_ready);
         end
         tick;
      end
      bus.out_ready = 1'b1;
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: in_ready got %b want 1", bus.in_ready);
      end
      tick;
      bus.in_valid = 1'b0;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00010, 16'h1234};
      $display("txn bp_or: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL bp_next_op: got %h want %h", got, exp);
      end
      tick;
   endtask

   task automatic test_shift;
      logic [22:0] got, exp;
      bus.out_ready = 1'b1;
      drive(OP_SHR, 16'h8001, 16'h0001, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b01010, 16'h4000};
      $display("txn shr: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL shr: got %h want %h", got, exp);
      end
      drive(OP_SAR, 16'h8000, 16'h000F, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00100, 16'hFFFF};
      $display("txn sar: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL sar: got %h want %h", got, exp);
      end
      drive(OP_SHL, 16'h1234, 16'h0000, 1'b1);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00010, 16'h1234};
      $display("txn shl0: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL shl_zero: got %h want %h", got, exp);
      end
      drive(OP_SHL, 16'h8001, 16'h0001, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b01010, 16'h0002};
      $display("txn shl1: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL shl_one: got %h want %h", got, exp);
      end
      bus.in_valid = 1'b0;
      tick;
   endtask

   task automatic test_logic;
      logic [22:0] got, exp;
      bus.out_ready = 1'b1;
      drive(OP_AND, 16'hF0F0, 16'hFF00, 1'b1);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00100, 16'hF000};
      $display("txn and: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL and: got %h want %h", got, exp);
      end
      drive(OP_NOT, 16'h00FF, 16'h1234, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00100, 16'hFF00};
      $display("txn not: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL not: got %h want %h", got, exp);
      end
      drive(OP_PASS2, 16'h5555, 16'h0000, 1'b1);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b11000, 16'h0000};
      $display("txn pass2: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL pass2: got %h want %h", got, exp);
      end
      drive(OP_PASS1, 16'h0001, 16'hAAAA, 1'b0);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00010, 16'h0001};
      $display("txn pass1: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL pass1: got %h want %h", got, exp);
      end
      drive(4'd14, 16'h8000, 16'h7777, 1'b1);
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00110, 16'h8000};
      $display("txn op14: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL op_reserved: got %h want %h", got, exp);
      end
      bus.in_valid = 1'b0;
      tick;
   endtask

   task automatic test_mul_reset;
      logic [22:0] got, exp;
      int late_valid;
      bus.out_ready = 1'b1;
      drive(OP_MUL, 16'h0003, 16'h0005, 1'b0);
      tick;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      rst = 1'b1;
      tick;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      $display("txn mul_reset: out_valid=%b res=%h flg=%b in_ready=%b", bus.out_valid, bus.res, bus.out_flg, bus.in_ready);
      n_vec++;
      if (got !== 23'h0) begin
         n_err++;
         $display("FAIL mulrst_outputs: got %h want %h", got, 23'h0);
      end
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mulrst_in_ready: got %b want 1", bus.in_ready);
      end
      rst = 1'b0;
      late_valid = 0;
      for (int i = 0; i < 24; i++) begin
         tick;
         if (bus.out_valid !== 1'b0) late_valid++;
      end
      n_vec++;
      if (late_valid != 0) begin
         n_err++;
         $display("FAIL mulrst_no_result: out_valid high %0d cycles want 0", late_valid);
      end
      drive(OP_ADD, 16'h0003, 16'h0005, 1'b0);
      tick;
      bus.in_valid = 1'b0;
      got = {bus.out_valid, bus.wr_en, bus.out_flg, bus.res};
      exp = {1'b1, 1'b1, 5'b00010, 16'h0008};
      $display("txn add_after_rst: res=%h flg=%b", bus.res, bus.out_flg);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL mulrst_recover: got %h want %h", got, exp);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub_cmp;
      test_mul(16'h0100, 16'h0100, 16'h0000, 5'b11001);
      test_mul(16'h00FF, 16'h0101, 16'hFFFF, 5'b00100);
      test_mul(16'hFFFF, 16'hFFFF, 16'h0001, 5'b01011);
      test_backpressure;
      test_shift;
      test_logic;
      test_mul_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
